irq_priority_ctrl: RTL and testbench
====================================

# irq_priority_ctrl

Sequential interrupt front-end that captures eight request lines, holds them as pending events, and resolves them with a fixed priority: bit 0 highest, bit 7 lowest. It presents one winning 3-bit ID at a time over a valid/ack handshake, then stays busy until the consumer signals end-of-interrupt. The block sits directly upstream of the consumer that services the ID. Unlike a purely combinational encoder, it never drives X: when no candidate exists, it holds its registered outputs.

## Interface
- NUM_REQ, 8, number of request lines; fixed at 8 for this revision.
- ID_W, 3, width of irq_id; equals log2(NUM_REQ).
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  8  request lines, synchronous to clk; a rising edge creates an event.
- mask  in  8  per-line enable; 1 = line may be presented, 0 = line is held pending but not presented.
- irq_ack  in  1  consumer accepts the presented ID; honoured only while irq_valid = 1.
- eoi  in  1  end-of-interrupt pulse; honoured only in SERVICE.
- irq_valid  out  1  an ID is being presented.
- irq_id  out  3  presented ID; stable while irq_valid = 1.
- busy  out  1  an accepted interrupt is in service.
- pending  out  8  current pending-event register.

## Operation
- Edge detect: req_q <= req every cycle.
  - edge[i] = req[i] & ~req_q[i].
  - req_q resets to 0, so a line already high at reset release produces one event.
- Pending register: for each bit, pending[i] <= edge[i] | (pending[i] & ~clr[i]).
  - clr is a one-hot of irq_id, active only on an accepted ack.
  - Set wins over clear in the same cycle.
- Candidate vector: cand = pending & mask.
  - Winner is the lowest set index of cand, encoded 0..7.
- FSM states: IDLE, PRESENT, SERVICE.
  - IDLE: when cand != 0, latch the winner into irq_id and go to PRESENT. Otherwise stay.
  - PRESENT: irq_valid = 1. irq_id is frozen, with no preemption even if a higher-priority event arrives or the mask changes. On irq_ack: clear pending[irq_id] and go to SERVICE.
  - SERVICE: busy = 1 and irq_valid = 0. On eoi go to IDLE.
- Ignored inputs:
  - irq_ack outside PRESENT.
  - eoi outside SERVICE.
  - irq_ack and eoi together in PRESENT: the ack is taken and the eoi is ignored.
- Masked lines keep their pending bit indefinitely. Unmasking a line later makes it eligible on the next IDLE evaluation.
- A repeated edge on a line that is already pending is absorbed: one event, no counting.
- irq_id holds its last value in IDLE and SERVICE.

## Timing
- Reset (rst_n = 0, asynchronous) forces:
  - state = IDLE
  - irq_valid = 0, busy = 0
  - irq_id = 3'b000
  - pending = 8'h00, req_q = 8'h00
- Reset applied mid-PRESENT or mid-SERVICE drops the event with no ack owed. The first edge after rst_n rises behaves as after power-up.
- Request to valid:
  - req[i] is first sampled high at edge k, so pending[i] = 1 after edge k.
  - irq_valid = 1 after edge k+1, a 2-cycle latency.
- Ack: irq_ack sampled high at edge m gives irq_valid = 0, busy = 1, and pending[id] = 0, all after edge m.
- EOI: eoi sampled at edge n gives busy = 0 after edge n. The earliest next irq_valid is after edge n+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan
- Reset then single request: req = 8'h20 from cycle 1 gives pending = 8'h20 after edge 1 and irq_valid = 1 with irq_id = 5 after edge 2. Ack then gives pending = 8'h00 and busy = 1; eoi returns busy = 0.
- Priority: req = 8'h88 in one cycle presents irq_id = 3 first. After ack and eoi, the next presentation is irq_id = 7, with no gap beyond 1 cycle.
- No preemption: while PRESENT with irq_id = 4, raising req[0] leaves irq_id = 4 unchanged until ack. After eoi, irq_id = 0 is presented.
- Mask: with mask = 8'hFE and req[0] rising, pending = 8'h01 and irq_valid stays 0 for 20 cycles. Setting mask = 8'hFF gives irq_valid = 1, irq_id = 0, two edges later.
- Set/clear collision: a new rising edge on req[2] in the same cycle as the ack for irq_id = 2 leaves pending[2] = 1 afterwards, and id 2 is presented again after eoi.
- Async reset mid-SERVICE: pulsing rst_n low between clock edges makes busy, irq_valid, pending, and irq_id go to 0 immediately. A req held high through reset yields a new event after the first post-reset edge.

Source files
------------

// File: rtl/irq_priority_ctrl.sv
// Eight-line edge-captured interrupt front-end with fixed priority (bit 0 highest).
// Presents one ID over a valid/ack handshake and stays busy until end-of-interrupt.
module irq_priority_ctrl #(
    parameter int NUM_REQ = 8,
    parameter int ID_W    = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic               irq_ack,
    input  logic               eoi,
    output logic               irq_valid,
    output logic [ID_W-1:0]    irq_id,
    output logic               busy,
    output logic [NUM_REQ-1:0] pending
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [NUM_REQ-1:0] req_q;
    logic [NUM_REQ-1:0] req_edge;
    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] clr;
    logic [ID_W-1:0]    winner;
    logic               load_id;
    logic               ack_take;

    assign req_edge = req & ~req_q;
    assign cand     = pending & mask;

    // Scan from the lowest priority upward so the lowest set index wins.
    always_comb begin
        winner = '0;
        for (int unsigned i = NUM_REQ; i > 0; i--) begin
            if (cand[i-1]) begin
                winner = ID_W'(i - 1);
            end
        end
    end

    always_comb begin
        next_state = state;
        load_id    = 1'b0;
        ack_take   = 1'b0;
        case (state)
            IDLE: begin
                if (|cand) begin
                    load_id    = 1'b1;
                    next_state = PRESENT;
                end
            end
            PRESENT: begin
                if (irq_ack) begin
                    ack_take   = 1'b1;
                    next_state = SERVICE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        clr = '0;
        if (ack_take) begin
            clr = NUM_REQ'(1) << irq_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req_q     <= '0;
            pending   <= '0;
            irq_id    <= '0;
            irq_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= next_state;
            req_q     <= req;
            // A fresh edge re-arms a line even while its previous event is being cleared.
            pending   <= req_edge | (pending & ~clr);
            if (load_id) begin
                irq_id <= winner;
            end
            irq_valid <= (next_state == PRESENT);
            busy      <= (next_state == SERVICE);
        end
    end

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Self-checking bench for irq_priority_ctrl: directed scenarios plus a randomized run
// checked against an event-level reference model.
module tb_irq_priority_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] mask;
    logic       irq_ack;
    logic       eoi;
    logic       irq_valid;
    logic [2:0] irq_id;
    logic       busy;
    logic [7:0] pending;

    int n_checks;
    int n_fail;

    // Reference model state
    logic [7:0] m_pend;
    logic [7:0] m_req_q;
    logic [2:0] m_id;
    logic       m_valid;
    logic       m_busy;

    irq_priority_ctrl #(.NUM_REQ(8), .ID_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mask      (mask),
        .irq_ack   (irq_ack),
        .eoi       (eoi),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .busy      (busy),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pend  = '0;
        m_req_q = '0;
        m_id    = '0;
        m_valid = 1'b0;
        m_busy  = 1'b0;
    endtask

    // Advance the model with the inputs seen at the coming edge, then step past that edge.
    task automatic cycle();
        logic [7:0] rise;
        logic [7:0] cnd;
        logic [7:0] iso;
        logic [7:0] clrv;
        if (!rst_n) begin
            model_reset();
        end else begin
            rise = req & ~m_req_q;
            cnd  = m_pend & mask;
            clrv = '0;
            if (m_valid) begin
                if (irq_ack) begin
                    clrv    = 8'd1 << m_id;
                    m_valid = 1'b0;
                    m_busy  = 1'b1;
                end
            end else if (m_busy) begin
                if (eoi) m_busy = 1'b0;
            end else if (cnd != 8'd0) begin
                iso     = cnd & (~cnd + 8'd1);
                m_id    = 3'($clog2(iso));
                m_valid = 1'b1;
            end
            m_pend  = rise | (m_pend & ~clrv);
            m_req_q = req;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; mask = 8'hFF; irq_ack = 0; eoi = 0;
        model_reset();
        #2;
        n_checks++;
        if ({irq_valid, busy, irq_id, pending} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", {irq_valid, busy, irq_id, pending}, 13'd0);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        req = 8'h20;
        cycle();
        n_checks++;
        if (pending !== 8'h20 || irq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pending: got pend=%h valid=%b expected pend=20 valid=0", pending, irq_valid);
        end
        cycle();
        n_checks++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd5) begin
            n_fail++;
            $display("FAIL single_present: got valid=%b id=%0d expected valid=1 id=5", irq_valid, irq_id);
        end
        irq_ack = 1;
        cycle();
        irq_ack = 0;
        n_checks++;
        if (pending !== 8'h00 || busy !== 1'b1 || irq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack: got pend=%h busy=%b valid=%b expected 00 1 0", pending, busy, irq_valid);
        end
        eoi = 1;
        cycle();
        eoi = 0;
        n_checks++;
        if (busy !== 1'b0 || irq_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_eoi: got busy=%b valid=%b expected 0 0", busy, irq_valid);
        end
        req = 8'h00;
        cycle();
    endtask

    task automatic test_priority();
        req = 8'h88;
        cycle();
        req = 8'h00;
        cycle();
        n_checks++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd3) begin
            n_fail++;
            $display("FAIL prio_first: got valid=%b id=%0d expected 1 3", irq_valid, irq_id);
        end
        irq_ack = 1; cycle(); irq_ack = 0;
        eoi = 1; cycle(); eoi = 0;
        cycle();
        n_checks++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd7) begin
            n_fail++;
            $display("FAIL prio_second: got valid=%b id=%0d expected 1 7", irq_valid, irq_id);
        end
        irq_ack = 1; cycle(); irq_ack = 0;
        eoi = 1; cycle(); eoi = 0;
        cycle();
    endtask

    task automatic test_no_preempt();
        req = 8'h10;
        cycle();
        cycle();
        req = 8'h11;
        for (int k = 0; k < 4; k++) begin
            cycle();
            n_checks++;
            if (irq_valid !== 1'b1 || irq_id !== 3'd4) begin
                n_fail++;
                $display("FAIL no_preempt[%0d]: got valid=%b id=%0d expected 1 4", k, irq_valid, irq_id);
            end
        end
        irq_ack = 1; cycle(); irq_ack = 0;
        eoi = 1; cycle(); eoi = 0;
        cycle();
        n_checks++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd0) begin
            n_fail++;
            $display("FAIL no_preempt_after: got valid=%b id=%0d expected 1 0", irq_valid, irq_id);
        end
        irq_ack = 1; cycle(); irq_ack = 0;
        eoi = 1; cycle(); eoi = 0;
        req = 8'h00;
        cycle();
    endtask

    task automatic test_mask();
        mask = 8'hFE;
        req  = 8'h01;
        for (int k = 0; k < 20; k++) begin
            cycle();
            n_checks++;
            if (irq_valid !== 1'b0 || pending !== 8'h01) begin
                n_fail++;
                $display("FAIL mask_hold[%0d]: got valid=%b pend=%h expected 0 01", k, irq_valid, pending);
            end
        end
        mask = 8'hFF;
        cycle();
        cycle();
        n_checks++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd0) begin
            n_fail++;
            $display("FAIL mask_release: got valid=%b id=%0d expected 1 0", irq_valid, irq_id);
        end
        irq_ack = 1; cycle(); irq_ack = 0;
        eoi = 1; cycle(); eoi = 0;
        req = 8'h00;
        cycle();
    endtask

    task automatic test_collision();
        req = 8'h04;
        cycle();
        cycle();
        req = 8'h00;
        cycle();
        req = 8'h04; irq_ack = 1;
        cycle();
        irq_ack = 0;
        n_checks++;
        if (pending[2] !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_pend: got pend=%h busy=%b expected bit2=1 busy=1", pending, busy);
        end
        eoi = 1; cycle(); eoi = 0;
        cycle();
        n_checks++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd2) begin
            n_fail++;
            $display("FAIL collision_again: got valid=%b id=%0d expected 1 2", irq_valid, irq_id);
        end
        irq_ack = 1; cycle(); irq_ack = 0;
        eoi = 1; cycle(); eoi = 0;
        req = 8'h00;
        cycle();
    endtask

    task automatic test_async_reset();
        req = 8'h08;
        cycle();
        cycle();
        irq_ack = 1; cycle(); irq_ack = 0;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({irq_valid, busy, irq_id, pending} !== 13'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", {irq_valid, busy, irq_id, pending}, 13'd0);
        end
        #1;
        rst_n = 1'b1;
        model_reset();
        cycle();
        n_checks++;
        if (pending !== 8'h08 || irq_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_event: got pend=%h valid=%b busy=%b expected 08 0 0", pending, irq_valid, busy);
        end
        cycle();
        n_checks++;
        if (irq_valid !== 1'b1 || irq_id !== 3'd3) begin
            n_fail++;
            $display("FAIL post_reset_present: got valid=%b id=%0d expected 1 3", irq_valid, irq_id);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            req     = 8'($urandom);
            mask    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            irq_ack = ($urandom_range(0, 2) == 0);
            eoi     = ($urandom_range(0, 2) == 0);
            cycle();
            n_checks++;
            if ({irq_valid, busy, irq_id, pending} !== {m_valid, m_busy, m_id, m_pend}) begin
                n_fail++;
                $display("FAIL random[%0d]: got valid=%b busy=%b id=%0d pend=%h expected valid=%b busy=%b id=%0d pend=%h",
                         k, irq_valid, busy, irq_id, pending, m_valid, m_busy, m_id, m_pend);
            end
        end
        irq_ack = 0;
        eoi = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_priority();
        test_no_preempt();
        test_mask();
        test_collision();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
